atomic_bus_master: RTL and testbench

//  Wishbone initiator that executes RV32A atomics (lr.w, sc.w, amo*.w) as tagged bus cycles toward the IO/memory

---
 rtl/atomic_bus_master.sv | 227 ++++++++++++++++++++++
 tb/tb_atomic_bus_master.sv | 397 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/atomic_bus_master.sv
// Wishbone initiator for RV32A lr.w/sc.w/amo*.w, issuing tagged, lockable bus cycles.
// addr_tag_o = {mode, lock}; define AMO_MINMAX_EN to support amomin/amomax(u).
module atomic_bus_master #(
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_i,
    input  logic [3:0]  req_op_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_data_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        fault_o,
    output logic [31:0] result_o,
    output logic        cyc_o,
    output logic        stb_o,
    output logic        we_o,
    output logic [31:0] addr_o,
    output logic [2:0]  addr_tag_o,
    output logic [31:0] data_o,
    output logic [3:0]  sel_o,
    input  logic        ack_i,
    input  logic        err_i,
    input  logic [31:0] data_i,
    input  logic        data_tag_i
);
    localparam logic [1:0] TAG_MODE_LRSC = 2'd1;
    localparam logic [1:0] TAG_MODE_AMO  = 2'd2;
    localparam logic       TAG_LOCK      = 1'b1;
    localparam logic       TAG_UNLOCK    = 1'b0;

    localparam logic [3:0] OP_LR   = 4'd0;
    localparam logic [3:0] OP_SC   = 4'd1;
    localparam logic [3:0] OP_ADD  = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4;
    localparam logic [3:0] OP_AND  = 4'd5;
    localparam logic [3:0] OP_OR   = 4'd6;
`ifdef AMO_MINMAX_EN
    localparam logic [3:0] OP_MIN  = 4'd7;
    localparam logic [3:0] OP_MAX  = 4'd8;
    localparam logic [3:0] OP_MINU = 4'd9;
    localparam logic [3:0] OP_MAXU = 4'd10;
`endif

    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TMO_LAST =
        TW'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);
    localparam bit TMO_EN = (TIMEOUT_CYCLES != 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_GAP,
        S_WR,
        S_FIN
    } state_t;

    state_t        state_q, state_d;
    logic [3:0]    op_q, op_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   rs2_q, rs2_d;
    logic [31:0]   old_q, old_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [31:0]   result_q, result_d;
    logic          fault_q, fault_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          tmo_hit;
    logic [1:0]    mode_w;

    function automatic logic op_illegal(input logic [3:0] op);
`ifdef AMO_MINMAX_EN
        return op > OP_MAXU;
`else
        return op > OP_OR;
`endif
    endfunction

    function automatic logic [31:0] amo_calc(input logic [3:0]  op,
                                             input logic [31:0] a,
                                             input logic [31:0] b);
        logic [31:0] r;
        r = b;
        case (op)
            OP_ADD:  r = a + b;
            OP_XOR:  r = a ^ b;
            OP_AND:  r = a & b;
            OP_OR:   r = a | b;
`ifdef AMO_MINMAX_EN
            OP_MIN:  r = ($signed(a) < $signed(b)) ? a : b;
            OP_MAX:  r = ($signed(a) > $signed(b)) ? a : b;
            OP_MINU: r = (a < b) ? a : b;
            OP_MAXU: r = (a > b) ? a : b;
`endif
            default: r = b;
        endcase
        return r;
    endfunction

    assign tmo_hit = TMO_EN && (tmo_q == TMO_LAST);
    assign mode_w  = (op_q == OP_LR || op_q == OP_SC) ? TAG_MODE_LRSC : TAG_MODE_AMO;

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        addr_d     = addr_q;
        rs2_d      = rs2_q;
        old_d      = old_q;
        wdata_d    = wdata_q;
        result_d   = result_q;
        fault_d    = fault_q;
        tmo_d      = '0;
        cyc_o      = 1'b0;
        stb_o      = 1'b0;
        we_o       = 1'b0;
        addr_tag_o = '0;
        case (state_q)
            S_IDLE: begin
                if (req_i) begin
                    op_d    = req_op_i;
                    addr_d  = req_addr_i;
                    rs2_d   = req_data_i;
                    wdata_d = req_data_i;
                    fault_d = 1'b0;
                    if (req_addr_i[1:0] != 2'b00 || op_illegal(req_op_i)) begin
                        fault_d  = 1'b1;
                        result_d = '0;
                        state_d  = S_FIN;
                    end else if (req_op_i == OP_SC) begin
                        state_d = S_WR;
                    end else begin
                        state_d = S_RD;
                    end
                end
            end
            S_RD: begin
                cyc_o      = 1'b1;
                stb_o      = 1'b1;
                addr_tag_o = {mode_w, TAG_LOCK};
                if (err_i) begin
                    fault_d  = 1'b1;
                    result_d = '0;
                    state_d  = S_FIN;
                end else if (ack_i) begin
                    old_d = data_i;
                    if (op_q == OP_LR) begin
                        result_d = data_i;
                        state_d  = S_FIN;
                    end else begin
                        state_d = S_GAP;
                    end
                end else if (tmo_hit) begin
                    fault_d  = 1'b1;
                    result_d = '0;
                    state_d  = S_FIN;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            S_GAP: begin
                // Strobe low for one cycle so the responder drops its read ack.
                cyc_o      = 1'b1;
                addr_tag_o = {mode_w, TAG_LOCK};
                wdata_d    = amo_calc(op_q, old_q, rs2_q);
                state_d    = S_WR;
            end
            S_WR: begin
                cyc_o      = 1'b1;
                stb_o      = 1'b1;
                we_o       = 1'b1;
                addr_tag_o = {mode_w, TAG_UNLOCK};
                if (err_i) begin
                    fault_d  = 1'b1;
                    result_d = '0;
                    state_d  = S_FIN;
                end else if (ack_i) begin
                    result_d = (op_q == OP_SC) ? {31'b0, data_tag_i} : old_q;
                    state_d  = S_FIN;
                end else if (tmo_hit) begin
                    fault_d  = 1'b1;
                    result_d = '0;
                    state_d  = S_FIN;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign busy_o   = (state_q != S_IDLE);
    assign done_o   = (state_q == S_FIN);
    assign fault_o  = done_o & fault_q;
    assign result_o = result_q;
    assign sel_o    = cyc_o ? 4'hF : 4'h0;
    assign addr_o   = cyc_o ? addr_q : '0;
    assign data_o   = we_o ? wdata_q : '0;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= S_IDLE;
            op_q     <= '0;
            addr_q   <= '0;
            rs2_q    <= '0;
            old_q    <= '0;
            wdata_q  <= '0;
            result_q <= '0;
            fault_q  <= 1'b0;
            tmo_q    <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            addr_q   <= addr_d;
            rs2_q    <= rs2_d;
            old_q    <= old_d;
            wdata_q  <= wdata_d;
            result_q <= result_d;
            fault_q  <= fault_d;
            tmo_q    <= tmo_d;
        end
    end
endmodule

// File: tb/tb_atomic_bus_master.sv
// Bench for atomic_bus_master: directed vector table, hand-written reset sequence,
// and random transactions checked against a phase-level reference model.
module tb_atomic_bus_master;
    localparam int TMO = 16;
`ifdef AMO_MINMAX_EN
    localparam bit MINMAX = 1'b1;
`else
    localparam bit MINMAX = 1'b0;
`endif

    typedef struct {
        logic [3:0]  op;
        logic [31:0] addr;
        logic [31:0] rs2;
        logic [31:0] old;
        logic        scf;
        int          waitc;
        int          errph;
        logic        noack;
        logic        poke;
    } stim_t;

    typedef struct {
        logic        fault;
        logic [31:0] result;
        logic [31:0] wdata;
        int          lat;
        int          nrd;
        int          nwr;
        int          nstb;
        int          ngap;
        logic [2:0]  rdtag;
        logic [2:0]  wrtag;
    } res_t;

    typedef struct {
        stim_t s;
        res_t  e;
    } vec_t;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        req_i;
    logic [3:0]  req_op_i;
    logic [31:0] req_addr_i;
    logic [31:0] req_data_i;
    logic        busy_o;
    logic        done_o;
    logic        fault_o;
    logic [31:0] result_o;
    logic        cyc_o;
    logic        stb_o;
    logic        we_o;
    logic [31:0] addr_o;
    logic [2:0]  addr_tag_o;
    logic [31:0] data_o;
    logic [3:0]  sel_o;
    logic        ack_i;
    logic        err_i;
    logic [31:0] data_i;
    logic        data_tag_i;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk_i = ~clk_i;

    atomic_bus_master #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .req_i      (req_i),
        .req_op_i   (req_op_i),
        .req_addr_i (req_addr_i),
        .req_data_i (req_data_i),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .fault_o    (fault_o),
        .result_o   (result_o),
        .cyc_o      (cyc_o),
        .stb_o      (stb_o),
        .we_o       (we_o),
        .addr_o     (addr_o),
        .addr_tag_o (addr_tag_o),
        .data_o     (data_o),
        .sel_o      (sel_o),
        .ack_i      (ack_i),
        .err_i      (err_i),
        .data_i     (data_i),
        .data_tag_i (data_tag_i)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic res_t res_clear();
        res_t r;
        r.fault  = 1'b0;
        r.result = '0;
        r.wdata  = '0;
        r.lat    = 0;
        r.nrd    = 0;
        r.nwr    = 0;
        r.nstb   = 0;
        r.ngap   = 0;
        r.rdtag  = '0;
        r.wrtag  = '0;
        return r;
    endfunction

    function automatic vec_t mk(
        input logic [3:0] op, input logic [31:0] addr, input logic [31:0] rs2,
        input logic [31:0] old, input logic scf, input int waitc, input int errph,
        input logic noack, input logic poke, input logic fault,
        input logic [31:0] result, input logic [31:0] wdata, input int lat,
        input int nrd, input int nwr, input int nstb, input int ngap,
        input logic [2:0] rdtag, input logic [2:0] wrtag);
        vec_t v;
        v.s.op = op; v.s.addr = addr; v.s.rs2 = rs2; v.s.old = old;
        v.s.scf = scf; v.s.waitc = waitc; v.s.errph = errph;
        v.s.noack = noack; v.s.poke = poke;
        v.e.fault = fault; v.e.result = result; v.e.wdata = wdata;
        v.e.lat = lat; v.e.nrd = nrd; v.e.nwr = nwr; v.e.nstb = nstb;
        v.e.ngap = ngap; v.e.rdtag = rdtag; v.e.wrtag = wrtag;
        return v;
    endfunction

    function automatic logic [31:0] amo_ref(input logic [3:0] op,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
        int sa, sb;
        sa = int'(a);
        sb = int'(b);
        case (op)
            4'd2:    return b;
            4'd3:    return a + b;
            4'd4:    return a ^ b;
            4'd5:    return a & b;
            4'd6:    return a | b;
            4'd7:    return (sa < sb) ? a : b;
            4'd8:    return (sa > sb) ? a : b;
            4'd9:    return (a < b) ? a : b;
            4'd10:   return (a > b) ? a : b;
            default: return 32'h0;
        endcase
    endfunction

    // Each bus phase lasts waitc+1 cycles (or TMO with no ack); add req, gap and done cycles.
    function automatic res_t model(input stim_t s);
        res_t r;
        int   plen;
        logic legal, is_lr, is_sc;
        r = res_clear();
        r.lat = 1;
        legal = (s.op <= 4'd6) || (MINMAX && s.op <= 4'd10);
        if (!legal || s.addr[1:0] != 2'b00) begin
            r.fault = 1'b1;
            r.lat = 2;
            return r;
        end
        plen  = s.noack ? TMO : s.waitc + 1;
        is_lr = (s.op == 4'd0);
        is_sc = (s.op == 4'd1);
        if (!is_sc) begin
            r.nrd   = 1;
            r.nstb += plen;
            r.lat  += plen;
            r.rdtag = is_lr ? 3'b011 : 3'b101;
            if (s.noack || s.errph == 1) begin
                r.fault = 1'b1;
                r.lat  += 1;
                return r;
            end
            if (is_lr) begin
                r.result = s.old;
                r.lat   += 1;
                return r;
            end
            r.ngap = 1;
            r.lat += 1;
        end
        r.nwr   = 1;
        r.nstb += plen;
        r.lat  += plen;
        r.wrtag = is_sc ? 3'b010 : 3'b100;
        r.wdata = is_sc ? s.rs2 : amo_ref(s.op, s.old, s.rs2);
        if (s.noack || s.errph == 2) r.fault = 1'b1;
        else r.result = is_sc ? {31'b0, s.scf} : s.old;
        r.lat += 1;
        return r;
    endfunction

    task automatic run_txn(input stim_t s, output res_t o, output int bad);
        logic        prev_stb;
        logic        done;
        int          run;
        logic [67:0] cap;
        o = res_clear();
        bad = 0;
        prev_stb = 1'b0;
        done = 1'b0;
        run = 0;
        cap = '0;
        @(negedge clk_i);
        req_op_i = s.op;
        req_addr_i = s.addr;
        req_data_i = s.rs2;
        req_i = 1'b1;
        for (int c = 2; c <= 60 && !done; c++) begin
            @(negedge clk_i);
            req_i = s.poke;
            if (s.poke) begin
                req_op_i = 4'd1;
                req_addr_i = 32'h0000_9000;
                req_data_i = 32'hBAD0_BAD0;
            end
            if (sel_o !== (cyc_o ? 4'hF : 4'h0)) bad++;
            if (stb_o) begin
                if (!cyc_o) bad++;
                if (!prev_stb) begin
                    cap = {addr_o, addr_tag_o, we_o, data_o};
                    run = 0;
                    if (we_o) begin
                        o.nwr++;
                        o.wrtag = addr_tag_o;
                        o.wdata = data_o;
                    end else begin
                        o.nrd++;
                        o.rdtag = addr_tag_o;
                    end
                    if (addr_o !== s.addr) bad++;
                end else if (cap !== {addr_o, addr_tag_o, we_o, data_o}) begin
                    bad++;
                end
                run++;
                o.nstb++;
                ack_i = !s.noack && (run > s.waitc);
                err_i = ack_i && ((s.errph == 1 && !we_o) || (s.errph == 2 && we_o));
                data_i = ack_i ? s.old : 32'hA5A5_5A5A;
                data_tag_i = s.scf;
            end else begin
                ack_i = 1'b0;
                err_i = 1'b0;
                data_i = 32'h0;
                data_tag_i = 1'b0;
                if (cyc_o) o.ngap++;
            end
            prev_stb = stb_o;
            if (done_o) begin
                done = 1'b1;
                o.lat = c;
                o.fault = fault_o;
                o.result = result_o;
            end
        end
        req_i = 1'b0;
        ack_i = 1'b0;
        err_i = 1'b0;
        if (!done) o.lat = -1;
        @(negedge clk_i);
        if (busy_o || done_o || result_o !== o.result) bad++;
    endtask

    task automatic cmp_res(input string nm, input res_t o, input res_t e, input int bad);
        chk({nm, ".fault"}, 32'(o.fault), 32'(e.fault));
        chk({nm, ".result"}, o.result, e.result);
        chk({nm, ".wdata"}, o.wdata, e.wdata);
        chk({nm, ".latency"}, o.lat, e.lat);
        chk({nm, ".rd_phases"}, o.nrd, e.nrd);
        chk({nm, ".wr_phases"}, o.nwr, e.nwr);
        chk({nm, ".stb_cycles"}, o.nstb, e.nstb);
        chk({nm, ".gap_cycles"}, o.ngap, e.ngap);
        chk({nm, ".rd_tag"}, 32'(o.rdtag), 32'(e.rdtag));
        chk({nm, ".wr_tag"}, 32'(o.wrtag), 32'(e.wrtag));
        chk({nm, ".protocol"}, bad, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t  tbl[$];
        res_t  o;
        stim_t s;
        int    bad;
        int    nd;
        int    r;

        rst_i = 1'b1;
        req_i = 1'b0;
        req_op_i = '0;
        req_addr_i = '0;
        req_data_i = '0;
        ack_i = 1'b0;
        err_i = 1'b0;
        data_i = '0;
        data_tag_i = 1'b0;

        tbl.push_back(mk(0, 32'h1000, 0, 32'hDEADBEEF, 0, 0, 0, 0, 0,
                         0, 32'hDEADBEEF, 0, 3, 1, 0, 1, 0, 3'b011, 3'b000));
        tbl.push_back(mk(1, 32'h1000, 32'h55, 0, 0, 0, 0, 0, 0,
                         0, 0, 32'h55, 3, 0, 1, 1, 0, 3'b000, 3'b010));
        tbl.push_back(mk(1, 32'h1000, 32'h55, 0, 1, 0, 0, 0, 0,
                         0, 1, 32'h55, 3, 0, 1, 1, 0, 3'b000, 3'b010));
        tbl.push_back(mk(3, 32'h2000, 7, 5, 0, 0, 0, 0, 1,
                         0, 5, 12, 5, 1, 1, 2, 1, 3'b101, 3'b100));
`ifdef AMO_MINMAX_EN
        tbl.push_back(mk(10, 32'h2004, 1, 32'hFFFFFFFF, 0, 0, 0, 0, 0,
                         0, 32'hFFFFFFFF, 32'hFFFFFFFF, 5, 1, 1, 2, 1, 3'b101, 3'b100));
        tbl.push_back(mk(8, 32'h2008, 1, 32'hFFFFFFFF, 0, 0, 0, 0, 0,
                         0, 32'hFFFFFFFF, 1, 5, 1, 1, 2, 1, 3'b101, 3'b100));
`else
        tbl.push_back(mk(10, 32'h2004, 1, 32'hFFFFFFFF, 0, 0, 0, 0, 0,
                         1, 0, 0, 2, 0, 0, 0, 0, 3'b000, 3'b000));
        tbl.push_back(mk(8, 32'h2008, 1, 32'hFFFFFFFF, 0, 0, 0, 0, 0,
                         1, 0, 0, 2, 0, 0, 0, 0, 3'b000, 3'b000));
`endif
        tbl.push_back(mk(0, 32'h1002, 0, 32'h1234, 0, 0, 0, 0, 0,
                         1, 0, 0, 2, 0, 0, 0, 0, 3'b000, 3'b000));
        tbl.push_back(mk(2, 32'h3000, 32'hAA, 32'h11, 0, 0, 1, 0, 0,
                         1, 0, 0, 3, 1, 0, 1, 0, 3'b101, 3'b000));
        tbl.push_back(mk(0, 32'h4000, 0, 32'h99, 0, 0, 0, 1, 0,
                         1, 0, 0, 18, 1, 0, 16, 0, 3'b011, 3'b000));
        tbl.push_back(mk(11, 32'h5000, 1, 2, 0, 0, 0, 0, 0,
                         1, 0, 0, 2, 0, 0, 0, 0, 3'b000, 3'b000));
        tbl.push_back(mk(4, 32'h6000, 32'hFF, 32'hF0F0, 0, 2, 0, 0, 1,
                         0, 32'hF0F0, 32'hF00F, 9, 1, 1, 6, 1, 3'b101, 3'b100));
        tbl.push_back(mk(1, 32'h7000, 32'h33, 0, 0, 0, 2, 0, 0,
                         1, 0, 32'h33, 3, 0, 1, 1, 0, 3'b000, 3'b010));
        tbl.push_back(mk(5, 32'h8000, 32'h0F0F0F0F, 32'h12345678, 0, 1, 0, 0, 0,
                         0, 32'h12345678, 32'h02040608, 7, 1, 1, 4, 1, 3'b101, 3'b100));

        @(negedge clk_i);
        chk("reset.ctrl", 32'({cyc_o, stb_o, we_o, sel_o, addr_tag_o, busy_o, done_o, fault_o}), 0);
        chk("reset.addr", addr_o, 0);
        chk("reset.data", data_o, 0);
        chk("reset.result", result_o, 0);
        rst_i = 1'b0;

        foreach (tbl[i]) begin
            run_txn(tbl[i].s, o, bad);
            cmp_res($sformatf("vec%0d", i), o, tbl[i].e, bad);
        end

        @(negedge clk_i);
        req_op_i = 4'd1;
        req_addr_i = 32'h0000_A000;
        req_data_i = 32'h77;
        req_i = 1'b1;
        @(negedge clk_i);
        req_i = 1'b0;
        chk("midwr.stb_we", 32'({stb_o, we_o}), 3);
        chk("midwr.data", data_o, 32'h77);
        rst_i = 1'b1;
        #1;
        chk("midwr.rst_ctrl", 32'({cyc_o, stb_o, we_o, sel_o, addr_tag_o, busy_o, done_o, fault_o}), 0);
        chk("midwr.rst_addr", addr_o, 0);
        chk("midwr.rst_data", data_o, 0);
        chk("midwr.rst_result", result_o, 0);
        @(negedge clk_i);
        rst_i = 1'b0;
        nd = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk_i);
            if (done_o || busy_o || stb_o) nd++;
        end
        chk("midwr.no_done", nd, 0);

        for (int k = 0; k < 40; k++) begin
            if ($urandom_range(0, 7) == 0) s.op = 4'($urandom_range(11, 15));
            else s.op = 4'($urandom_range(0, 10));
            s.addr = $urandom;
            if ($urandom_range(0, 7) != 0) s.addr[1:0] = 2'b00;
            s.rs2 = $urandom;
            s.old = $urandom;
            if ($urandom_range(0, 3) == 0) s.old = s.rs2 ^ 32'h8000_0000;
            s.scf = 1'($urandom_range(0, 1));
            s.waitc = int'($urandom_range(0, 2));
            r = int'($urandom_range(0, 15));
            s.errph = (r == 0) ? 1 : (r == 1) ? 2 : 0;
            s.noack = (r == 2);
            s.poke = 1'($urandom_range(0, 1));
            run_txn(s, o, bad);
            cmp_res($sformatf("rnd%0d", k), o, model(s), bad);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
